// File: rtl/store_trace_uart.sv
// Store trace streamer: captures every memory-stage store {addr,data} into a FIFO
// and sends each one out as a 9-byte 8N1 UART record (0xA5 header, addr MSB first, data MSB first).
module store_trace_uart #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemWriteM,
  input  logic [31:0]             ALUResultM,
  input  logic [31:0]             WriteDataM,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    overflow,
  output logic [7:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  state_t        r_state;
  logic          r_txd;
  logic [63:0]   r_rec;
  logic [7:0]    r_byte;
  logic [3:0]    r_byteIdx;
  logic [2:0]    r_bitIdx;
  logic [CW-1:0] r_baudCnt;
  logic          r_overflow;
  logic [7:0]    r_dropCnt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Full when the wrap bits differ but the slot indices match.
  assign w_full = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop  = (r_state == LOAD);
  assign w_push = MemWriteM && (!w_full || w_pop);
  assign w_drop = MemWriteM && w_full && !w_pop;

  assign level    = r_wrPtr - r_rdPtr;
  assign busy     = (r_state != IDLE) || (level != '0);
  assign uart_tx  = r_txd;
  assign overflow = r_overflow;
  assign drop_cnt = r_dropCnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= {ALUResultM, WriteDataM};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCnt != 8'hFF) r_dropCnt <= r_dropCnt + 8'd1;
      end
    end
  end

  // r_byte shifts right as bits go out; r_rec shifts left as bytes are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_txd     <= 1'b1;
      r_rec     <= '0;
      r_byte    <= '0;
      r_byteIdx <= '0;
      r_bitIdx  <= '0;
      r_baudCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (level != '0) r_state <= LOAD;
        end
        LOAD: begin
          r_rec     <= r_mem[r_rdPtr[AW-1:0]];
          r_byte    <= 8'hA5;
          r_byteIdx <= '0;
          r_baudCnt <= BAUD_RELOAD;
          r_txd     <= 1'b0;
          r_state   <= START;
        end
        START: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BAUD_RELOAD;
            r_bitIdx  <= '0;
            r_txd     <= r_byte[0];
            r_byte    <= {1'b0, r_byte[7:1]};
            r_state   <= DATA;
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        DATA: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BAUD_RELOAD;
            if (r_bitIdx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_txd    <= r_byte[0];
              r_byte   <= {1'b0, r_byte[7:1]};
            end
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        STOP: begin
          if (r_baudCnt == '0) begin
            if (r_byteIdx < 4'd8) begin
              r_byteIdx <= r_byteIdx + 4'd1;
              r_byte    <= r_rec[63:56];
              r_rec     <= {r_rec[55:0], 8'h00};
              r_baudCnt <= BAUD_RELOAD;
              r_txd     <= 1'b0;
              r_state   <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baudCnt <= r_baudCnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_trace_uart.sv
// Bench for store_trace_uart: directed stores push expected UART bytes into a queue;
// a free-running monitor decodes every frame on uart_tx and pops/compares.
module tb_store_trace_uart;

  localparam int DIV    = 10;
  localparam int FRAME  = 10 * DIV;
  localparam int RECORD = 9 * FRAME + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        uart_tx;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  store_trace_uart #(.CLK_HZ(1000), .BAUD(100), .DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one store from a falling edge; it is captured at the next rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input bit accept);
    MemWriteM  = 1'b1;
    ALUResultM = addr;
    WriteDataM = data;
    if (accept) begin
      expQ.push_back(8'hA5);
      for (int b = 3; b >= 0; b--) expQ.push_back(addr[8*b +: 8]);
      for (int b = 3; b >= 0; b--) expQ.push_back(data[8*b +: 8]);
    end
    @(negedge clk);
  endtask

  task automatic idleBus();
    MemWriteM  = 1'b0;
    ALUResultM = 'x;
    WriteDataM = 'x;
  endtask

  task automatic afterEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || expQ.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({name, "Timeout"}, 32'(n >= budget), 32'd0);
    checkOutput({name, "PendingBytes"}, 32'(expQ.size()), 32'd0);
    @(negedge clk);
  endtask

  // UART monitor: 100 samples per frame, one per cycle, starting at the first low cycle.
  initial begin : uartMonitor
    logic        prevTx;
    logic [99:0] s;
    logic [7:0]  got;
    logic        aborted;
    logic        timingOk;
    prevTx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && prevTx && !uart_tx) begin
        s       = '1;
        s[0]    = uart_tx;
        aborted = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(posedge clk);
          #1;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s[i] = uart_tx;
        end
        if (!aborted) begin
          timingOk = 1'b1;
          for (int i = 0; i < FRAME; i++)
            if (s[i] !== s[(i / DIV) * DIV]) timingOk = 1'b0;
          if (s[0] !== 1'b0 || s[FRAME - DIV] !== 1'b1) timingOk = 1'b0;
          checkOutput("bitTiming", 32'(timingOk), 32'd1);
          for (int b = 0; b < 8; b++) got[b] = s[(b + 1) * DIV];
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedByte: got 0x%0h, expected no frame at %0t", got, $time);
          end else begin
            checkOutput("uartByte", 32'(got), 32'(expQ.pop_front()));
          end
        end
      end
      prevTx = uart_tx;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    idleBus();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstUartTx", 32'(uart_tx), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstDropCnt", 32'(drop_cnt), 32'd0);
    checkOutput("rstLevel", 32'(level), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single store");
    applyStimulus(32'h0000_0064, 32'h0000_0019, 1'b1);
    idleBus();
    checkOutput("levelAfterPush", 32'(level), 32'd1);
    checkOutput("busyAfterPush", 32'(busy), 32'd1);
    afterEdges(1);
    checkOutput("txHighInLoad", 32'(uart_tx), 32'd1);
    checkOutput("levelInLoad", 32'(level), 32'd1);
    afterEdges(1);
    checkOutput("startLatency", 32'(uart_tx), 32'd0);
    checkOutput("levelAfterPop", 32'(level), 32'd0);
    afterEdges(RECORD - 3);
    checkOutput("busyLastCycle", 32'(busy), 32'd1);
    afterEdges(1);
    checkOutput("busyFall", 32'(busy), 32'd0);
    checkOutput("txIdleAfter", 32'(uart_tx), 32'd1);
    waitDrain("single", 200);

    // Burst of 19: pop at edge N+2 frees one slot, so stores 0..16 are accepted and 17,18 drop.
    $display("[TB] burst");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(32'h1000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), i <= 16);
      if (i == 16) begin
        checkOutput("burstFullLevel", 32'(level), 32'd16);
        checkOutput("burstNoDropYet", 32'(drop_cnt), 32'd0);
        checkOutput("burstNoOverflowYet", 32'(overflow), 32'd0);
      end
    end
    idleBus();
    checkOutput("burstLevel", 32'(level), 32'd16);
    checkOutput("burstOverflow", 32'(overflow), 32'd1);
    checkOutput("burstDropCnt", 32'(drop_cnt), 32'd2);

    // Record 0 ends at N+902, IDLE at N+903, pop (LOAD) at edge N+904.
    repeat (885) @(negedge clk);
    checkOutput("fullBeforePop", 32'(level), 32'd16);
    applyStimulus(32'h2000_0000, 32'h5A5A_0001, 1'b1);
    checkOutput("pushPopFullLevel", 32'(level), 32'd16);
    checkOutput("pushPopFullNoDrop", 32'(drop_cnt), 32'd2);

    for (int i = 0; i < 253; i++)
      applyStimulus(32'h3000_0000 + 32'(i), 32'hDEAD_0000 + 32'(i), 1'b0);
    checkOutput("dropCntAt255", 32'(drop_cnt), 32'd255);
    checkOutput("levelDuringDrops", 32'(level), 32'd16);
    for (int i = 0; i < 21; i++)
      applyStimulus(32'h3100_0000 + 32'(i), 32'hBEEF_0000 + 32'(i), 1'b0);
    idleBus();
    checkOutput("dropCntSaturated", 32'(drop_cnt), 32'd255);
    checkOutput("overflowSticky", 32'(overflow), 32'd1);
    waitDrain("burst", 20000);
    checkOutput("levelDrained", 32'(level), 32'd0);

    // Byte 4 (0x78) starts at M+402; its bit 0 (low) is on the line from M+412 to M+421.
    $display("[TB] reset mid-frame");
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    idleBus();
    repeat (420) @(negedge clk);
    checkOutput("txBeforeReset", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abortUartTx", 32'(uart_tx), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortLevel", 32'(level), 32'd0);
    checkOutput("abortOverflow", 32'(overflow), 32'd0);
    checkOutput("abortDropCnt", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("releaseUartTx", 32'(uart_tx), 32'd1);
    applyStimulus(32'h0000_0ABC, 32'h1122_3344, 1'b1);
    idleBus();
    waitDrain("fresh", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
